// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, FSM state encoding and settle-time limits for the
// ALU issue/capture stage.
package alu_pkg;

   localparam int ALU_WIDTH  = 8;
   localparam int ALU_OPW    = 3;

   // Settle time is counted down in a 4-bit counter, so 15 is the ceiling.
   localparam int SETTLE_MIN = 1;
   localparam int SETTLE_MAX = 15;
   localparam int CNT_W      = 4;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers one command into a sibling combinational ALU,
// waits SETTLE cycles, captures result/flags into result registers and an
// accumulator, then holds the result until the consumer takes it.
// Optional build macro ALU_STICKY_FLAGS_EN adds clr_sticky, sticky_ov and
// sticky_cout (flags accumulated across captures until cleared).
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH,
   parameter int OPW    = ALU_OPW,
   parameter int SETTLE = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OPW-1:0]   cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_use_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_z,
   input  logic             alu_ov,
   input  logic             alu_cout,
   input  logic             alu_sign,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_z,
   output logic             res_ov,
   output logic             res_cout,
   output logic             res_sign,
   output logic [WIDTH-1:0] acc,
   output logic             busy
`ifdef ALU_STICKY_FLAGS_EN
   ,
   input  logic             clr_sticky,
   output logic             sticky_ov,
   output logic             sticky_cout
`endif
);

   // An out-of-range settle time cannot be counted correctly; refuse to build.
   generate
      if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
         $error("alu_issue_ctrl: SETTLE must be in 1..15");
      end
   endgenerate

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] cnt_reg;

   logic accept;
   logic capture;
   logic retire;

   // Handshake events, derived from the current state only.
   assign accept  = (state_reg == S_IDLE)   && cmd_valid;
   assign capture = (state_reg == S_SETTLE) && (cnt_reg == '0);
   assign retire  = (state_reg == S_RESP)   && res_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic: IDLE -> SETTLE on accept, SETTLE -> RESP on capture,
   // RESP -> IDLE on retire. A command arriving in RESP is left for IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (accept)  state_next = S_SETTLE;
         S_SETTLE: if (capture) state_next = S_RESP;
         S_RESP:   if (retire)  state_next = S_IDLE;
         default:               state_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state; res_valid therefore drops with reset at once.
   always_comb begin
      cmd_ready = (state_reg == S_IDLE);
      busy      = (state_reg != S_IDLE);
      res_valid = (state_reg == S_RESP);
   end

   // Operand/opcode registers feeding the ALU; they change only on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
      end else if (accept) begin
         alu_a  <= cmd_use_acc ? acc : cmd_a;
         alu_b  <= cmd_b;
         alu_op <= cmd_op;
      end
   end

   // Settle counter: loaded with SETTLE-1 on accept so the capture lands
   // exactly SETTLE edges after the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_reg <= '0;
      else if (accept)
         cnt_reg <= CNT_W'(SETTLE - 1);
      else if (state_reg == S_SETTLE && cnt_reg != '0)
         cnt_reg <= cnt_reg - CNT_W'(1);
   end

   // Result and accumulator capture; values persist after retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_z    <= '0;
         res_ov   <= 1'b0;
         res_cout <= 1'b0;
         res_sign <= 1'b0;
         acc      <= '0;
      end else if (capture) begin
         res_z    <= alu_z;
         res_ov   <= alu_ov;
         res_cout <= alu_cout;
         res_sign <= alu_sign;
         acc      <= alu_z;
      end
   end

`ifdef ALU_STICKY_FLAGS_EN
   // Sticky flags: a clear coinciding with a capture still keeps the new flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_ov   <= 1'b0;
         sticky_cout <= 1'b0;
      end else if (clr_sticky) begin
         sticky_ov   <= capture & alu_ov;
         sticky_cout <= capture & alu_cout;
      end else if (capture) begin
         sticky_ov   <= sticky_ov   | alu_ov;
         sticky_cout <= sticky_cout | alu_cout;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: two instances (SETTLE=1 and SETTLE=3), each with a
// behavioural ALU stub, driven by directed and random commands and checked
// against a transaction-level model of the issue/capture behaviour.
module tb_alu_issue_ctrl;

   typedef struct packed {
      logic [7:0] z;
      logic       ov;
      logic       cout;
      logic       sign;
   } alu_res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       cmd_valid   [2];
   logic       cmd_ready   [2];
   logic [2:0] cmd_op      [2];
   logic [7:0] cmd_a       [2];
   logic [7:0] cmd_b       [2];
   logic       cmd_use_acc [2];
   logic [7:0] alu_a       [2];
   logic [7:0] alu_b       [2];
   logic [2:0] alu_op      [2];
   logic [7:0] alu_z       [2];
   logic       alu_ov      [2];
   logic       alu_cout    [2];
   logic       alu_sign    [2];
   logic       res_valid   [2];
   logic       res_ready   [2];
   logic [7:0] res_z       [2];
   logic       res_ov      [2];
   logic       res_cout    [2];
   logic       res_sign    [2];
   logic [7:0] acc         [2];
   logic       busy        [2];
`ifdef ALU_STICKY_FLAGS_EN
   logic       clr_sticky  [2];
   logic       sticky_ov   [2];
   logic       sticky_cout [2];
   logic       m_sov       [2];
   logic       m_scout     [2];
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] m_acc [2];

   // Reference ALU computed with plain integer arithmetic.
   function automatic alu_res_t alu_ref(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
      alu_res_t r;
      int ua, ub, sa, sb, s;
      ua = int'({24'd0, a});
      ub = int'({24'd0, b});
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      r = '0;
      case (op)
         3'd0: begin
            r.z = 8'((ua + ub) % 256);
            r.cout = (ua + ub) > 255;
            s = sa + sb;
            r.ov = (s > 127) || (s < -128);
         end
         3'd1: begin
            r.z = 8'((ua - ub + 256) % 256);
            r.cout = ua >= ub;
            s = sa - sb;
            r.ov = (s > 127) || (s < -128);
         end
         3'd2:    r.z = a & b;
         3'd3:    r.z = a | b;
         3'd4:    r.z = a ^ b;
         default: r.z = a;
      endcase
      r.sign = r.z[7];
      return r;
   endfunction

   function automatic int st_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      alu_res_t st;
      assign st            = alu_ref(alu_a[gi], alu_b[gi], alu_op[gi]);
      assign alu_z[gi]     = st.z;
      assign alu_ov[gi]    = st.ov;
      assign alu_cout[gi]  = st.cout;
      assign alu_sign[gi]  = st.sign;

      alu_issue_ctrl #(.WIDTH(8), .OPW(3), .SETTLE((gi == 0) ? 1 : 3)) u_dut (
         .clk         (clk),
         .rst         (rst),
         .cmd_valid   (cmd_valid[gi]),
         .cmd_ready   (cmd_ready[gi]),
         .cmd_op      (cmd_op[gi]),
         .cmd_a       (cmd_a[gi]),
         .cmd_b       (cmd_b[gi]),
         .cmd_use_acc (cmd_use_acc[gi]),
         .alu_a       (alu_a[gi]),
         .alu_b       (alu_b[gi]),
         .alu_op      (alu_op[gi]),
         .alu_z       (alu_z[gi]),
         .alu_ov      (alu_ov[gi]),
         .alu_cout    (alu_cout[gi]),
         .alu_sign    (alu_sign[gi]),
         .res_valid   (res_valid[gi]),
         .res_ready   (res_ready[gi]),
         .res_z       (res_z[gi]),
         .res_ov      (res_ov[gi]),
         .res_cout    (res_cout[gi]),
         .res_sign    (res_sign[gi]),
         .acc         (acc[gi]),
         .busy        (busy[gi])
`ifdef ALU_STICKY_FLAGS_EN
         ,
         .clr_sticky  (clr_sticky[gi]),
         .sticky_ov   (sticky_ov[gi]),
         .sticky_cout (sticky_cout[gi])
`endif
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; all driving and sampling happens 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_reset(input int d);
      check("rst_alu_a", alu_a[d], 0);
      check("rst_alu_b", alu_b[d], 0);
      check("rst_alu_op", alu_op[d], 0);
      check("rst_res_z", res_z[d], 0);
      check("rst_flags", {res_ov[d], res_cout[d], res_sign[d]}, 0);
      check("rst_acc", acc[d], 0);
      check("rst_res_valid", res_valid[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_cmd_ready", cmd_ready[d], 1);
   endtask

   // One full command: accept, settle, capture, backpressure for bp cycles,
   // then retire with a competing command held on the input.
   task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic ua, input int bp,
                        input logic clr_cap);
      logic [7:0] exp_a;
      alu_res_t   r;
      int         edges;
      exp_a = ua ? m_acc[d] : a;
      r = alu_ref(exp_a, b, op);
      check("pre_cmd_ready", cmd_ready[d], 1);
      cmd_valid[d] = 1'b1; cmd_a[d] = a; cmd_b[d] = b;
      cmd_op[d] = op; cmd_use_acc[d] = ua; res_ready[d] = 1'b0;
      step();
      check("acc_alu_a", alu_a[d], exp_a);
      check("acc_alu_b", alu_b[d], b);
      check("acc_alu_op", alu_op[d], op);
      check("acc_busy", busy[d], 1);
      check("acc_cmd_ready", cmd_ready[d], 0);
      // Keep presenting junk commands; they must all be ignored.
      cmd_a[d] = 8'($urandom); cmd_b[d] = 8'($urandom);
      cmd_op[d] = 3'($urandom); cmd_use_acc[d] = 1'($urandom);
      edges = 0;
      while (!res_valid[d] && edges < 32) begin
`ifdef ALU_STICKY_FLAGS_EN
         clr_sticky[d] = clr_cap && (edges + 1 == st_of(d));
`endif
         step();
`ifdef ALU_STICKY_FLAGS_EN
         clr_sticky[d] = 1'b0;
`endif
         edges++;
      end
      check("latency", edges, st_of(d));
      m_acc[d] = r.z;
`ifdef ALU_STICKY_FLAGS_EN
      if (clr_cap) begin m_sov[d] = 1'b0; m_scout[d] = 1'b0; end
      m_sov[d]   = m_sov[d]   | r.ov;
      m_scout[d] = m_scout[d] | r.cout;
      check("sticky_ov", sticky_ov[d], m_sov[d]);
      check("sticky_cout", sticky_cout[d], m_scout[d]);
`else
      if (clr_cap) check("clr_unused", 0, 0);
`endif
      check("cap_res_valid", res_valid[d], 1);
      check("cap_res_z", res_z[d], r.z);
      check("cap_flags", {res_ov[d], res_cout[d], res_sign[d]}, {r.ov, r.cout, r.sign});
      check("cap_acc", acc[d], r.z);
      check("cap_alu_a_held", alu_a[d], exp_a);
      for (int k = 0; k < bp; k++) begin
         step();
         check("bp_res_valid", res_valid[d], 1);
         check("bp_res_z", res_z[d], r.z);
         check("bp_cmd_ready", cmd_ready[d], 0);
      end
      res_ready[d] = 1'b1;
      step();
      check("ret_res_valid", res_valid[d], 0);
      check("ret_cmd_ready", cmd_ready[d], 1);
      check("ret_busy", busy[d], 0);
      check("ret_res_z_kept", res_z[d], r.z);
      check("ret_alu_a_held", alu_a[d], exp_a);
      cmd_valid[d] = 1'b0; res_ready[d] = 1'b0;
      $display("[TB] dut%0d op=%0d a=%02h b=%02h use_acc=%0b bp=%0d -> z=%02h ov=%0b cout=%0b lat=%0d",
               d, op, exp_a, b, ua, bp, r.z, r.ov, r.cout, edges);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d] = 0; cmd_op[d] = 0; cmd_a[d] = 0; cmd_b[d] = 0;
         cmd_use_acc[d] = 0; res_ready[d] = 0; m_acc[d] = 0;
`ifdef ALU_STICKY_FLAGS_EN
         clr_sticky[d] = 0; m_sov[d] = 0; m_scout[d] = 0;
`endif
      end
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
      check_idle_reset(0);
      check_idle_reset(1);

      // Basic add and accumulator chain (SETTLE=1), second with backpressure.
      issue(0, 8'hA9, 8'h83, 3'd0, 1'b0, 0, 1'b0);
      check("dir_add_z", res_z[0], 8'h2C);
      check("dir_add_flags", {res_ov[0], res_cout[0], res_sign[0]}, 3'b110);
      check("dir_add_acc", acc[0], 8'h2C);
      issue(0, 8'hFF, 8'h01, 3'd0, 1'b1, 5, 1'b0);
      check("dir_chain_z", res_z[0], 8'h2D);
      check("dir_chain_flags", {res_ov[0], res_cout[0], res_sign[0]}, 3'b000);
      check("dir_chain_acc", acc[0], 8'h2D);

      // SETTLE=3 latency and signed overflow.
      issue(1, 8'h69, 8'h43, 3'd0, 1'b0, 0, 1'b0);
      check("dir_s3_z", res_z[1], 8'hAC);
      check("dir_s3_flags", {res_ov[1], res_cout[1], res_sign[1]}, 3'b101);

      // Reset one cycle after accept: abort, nothing captured afterwards.
      cmd_valid[1] = 1'b1; cmd_a[1] = 8'h11; cmd_b[1] = 8'h22;
      cmd_op[1] = 3'd0; cmd_use_acc[1] = 1'b0;
      step();
      cmd_valid[1] = 1'b0;
      step();
      check("mid_busy_pre", busy[1], 1);
      rst = 1'b1;
      #1;
      check("mid_res_valid", res_valid[1], 0);
      check("mid_acc", acc[1], 0);
      check("mid_busy", busy[1], 0);
      for (int d = 0; d < 2; d++) begin
         m_acc[d] = 0;
`ifdef ALU_STICKY_FLAGS_EN
         m_sov[d] = 0; m_scout[d] = 0;
`endif
      end
      step();
      rst = 1'b0;
      repeat (4) step();
      check_idle_reset(1);
      check_idle_reset(0);

      // Accumulator cleared by reset feeds zero into ALU a.
      issue(1, 8'h55, 8'h10, 3'd0, 1'b1, 1, 1'b0);
      check("dir_acc0_z", res_z[1], 8'h10);

`ifdef ALU_STICKY_FLAGS_EN
      issue(0, 8'hA9, 8'h83, 3'd0, 1'b0, 0, 1'b0);
      issue(0, 8'h01, 8'h01, 3'd0, 1'b0, 0, 1'b0);
      check("dir_sticky_hold", sticky_ov[0], 1);
      issue(0, 8'hA9, 8'h83, 3'd0, 1'b0, 0, 1'b1);
      check("dir_sticky_setwins", sticky_ov[0], 1);
      clr_sticky[0] = 1'b1;
      step();
      clr_sticky[0] = 1'b0;
      m_sov[0] = 0; m_scout[0] = 0;
      check("dir_sticky_clr_ov", sticky_ov[0], 0);
      check("dir_sticky_clr_cout", sticky_cout[0], 0);
`endif

      // Random commands on both instances.
      for (int i = 0; i < 40; i++) begin
         issue($urandom_range(0, 1), 8'($urandom), 8'($urandom), 3'($urandom),
               1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Command-issue and result-capture stage wrapped around the combinational 8-bit ALU (ports a, b, op, z, ov, cout, sign).
- Accepts one command per valid/ready handshake and drives registered operands/op into the ALU.
- Waits a programmable settle time, then captures z and flags into result registers and an accumulator.
- Presents the result downstream with a valid/ready handshake.
- The ALU itself is instantiated beside this block in the parent.

Parameters:
WIDTH, 8, operand/result width (matches ALU a/b/z)
OPW, 3, ALU opcode width
SETTLE, 1, cycles from operand issue to capture; legal 1..15, any other value is an elaboration error

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command (high only in IDLE)
cmd_op  in  OPW  opcode
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_use_acc  in  1  1: ALU a is sourced from accumulator instead of cmd_a
alu_a  out  WIDTH  registered operand to ALU a
alu_b  out  WIDTH  registered operand to ALU b
alu_op  out  OPW  registered opcode to ALU op
alu_z  in  WIDTH  ALU result
alu_ov  in  1  ALU overflow
alu_cout  in  1  ALU carry out
alu_sign  in  1  ALU sign
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_z  out  WIDTH  captured result
res_ov  out  1  captured overflow
res_cout  out  1  captured carry
res_sign  out  1  captured sign
acc  out  WIDTH  accumulator (last captured z)
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - State is IDLE.
  - alu_a, alu_b, alu_op, res_z, res_ov, res_cout, res_sign, acc, settle counter are all 0.
  - res_valid=0, busy=0, cmd_ready=1 once rst deasserts.
- States: IDLE, SETTLE, RESP.
- IDLE: cmd_ready=1. When cmd_valid=1 at edge N:
  - alu_a <= cmd_use_acc ? acc : cmd_a.
  - alu_b <= cmd_b, alu_op <= cmd_op.
  - cnt <= SETTLE-1; go to SETTLE.
- SETTLE:
  - If cnt != 0, decrement.
  - If cnt == 0, capture on that edge: res_z/res_ov/res_cout/res_sign <= alu_*, acc <= alu_z, res_valid <= 1; go to RESP.
  - Capture occurs at edge N+SETTLE; res_valid is visible in the cycle after it.
- RESP:
  - res_* and res_valid are held stable until res_ready=1.
  - On res_ready=1 at an edge: res_valid <= 0, go to IDLE. res_* keep their values.
- alu_a/alu_b/alu_op hold their last values in all states; they change only on command accept.
- cmd_ready=0 in SETTLE and RESP; cmd_valid is ignored there.
  - A command and res_ready in the same RESP cycle: only the result is retired. The command is accepted in IDLE on the next cycle at the earliest, so throughput is one command per SETTLE+2 cycles minimum.
- cmd_use_acc with acc never written uses acc=0.
- No arithmetic in this block; widths pass through unchanged.
- Reset mid-operation (SETTLE or RESP): the command is aborted and nothing is captured; res_valid drops immediately and acc is cleared.

Optional Feature:
ALU_STICKY_FLAGS_EN
- Defined:
  - Adds input clr_sticky (1), outputs sticky_ov (1) and sticky_cout (1), all reset to 0.
  - At each capture, sticky_ov |= alu_ov and sticky_cout |= alu_cout.
  - clr_sticky=1 clears both; if clear and a set occur on the same edge, set wins.
- Not defined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- alu_pkg holds: ALU_WIDTH=8, ALU_OPW=3, state encoding localparams (S_IDLE=0, S_SETTLE=1, S_RESP=2), and the SETTLE legal range limits.
- No sub-module: the settle counter and FSM are inline. The ALU is a sibling instance in the parent, not a child.

Test Plan:
Bench ALU stub for op=3'b000 computes z=a+b, cout=carry, ov=signed overflow, sign=z[7].
- Basic add, SETTLE=1: cmd a=0xA9, b=0x83, op=0, use_acc=0 -> alu_a=0xA9/alu_b=0x83 after accept edge; res_valid next cycle after capture with res_z=0x2C, cout=1, ov=1, sign=0; acc=0x2C.
- Accumulator chain: then cmd use_acc=1, a=0xFF (ignored), b=0x01 -> alu_a=0x2C, res_z=0x2D, cout=0, ov=0; acc=0x2D.
- Backpressure: hold res_ready=0 for 5 cycles while cmd_valid=1 -> cmd_ready stays 0, res_* stable, no second accept; after res_ready pulse, next command accepted one cycle later.
- SETTLE=3: a=0x69, b=0x43 -> res_valid asserts exactly 3 edges after accept; res_z=0xAC, ov=1, sign=1, cout=0.
- Reset mid-SETTLE: assert rst one cycle after accept -> res_valid=0, acc=0x00, busy=0 immediately; no capture after release.
- ALU_STICKY_FLAGS_EN: add 0xA9+0x83 (ov=1), then 0x01+0x01 -> sticky_ov stays 1. Assert clr_sticky on a capture edge where ov=1 -> sticky_ov remains 1 (set wins).
